tiny_riscv_fetch: RTL and testbench



---
 rtl/tiny_riscv_pkg.sv | 17 +
 rtl/tiny_riscv_fetch_buffer.sv | 68 ++++++
 rtl/tiny_riscv_fetch.sv | 91 +++++++++
 tb/tb_tiny_riscv_fetch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tiny_riscv_pkg.sv
// Shared types and defaults for the tiny RISC-V fetch path.
package tiny_riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/tiny_riscv_fetch_buffer.sv
// Two-entry fetch packet FIFO; the head entry is the registered output to decode.
module tiny_riscv_fetch_buffer
  import tiny_riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic [XLEN-1:0] push_instr_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_instr_o,
  output logic            head_valid_o,
  output logic [1:0]      count_o
);

  fetch_pkt_t head_q, head_d;
  fetch_pkt_t tail_q, tail_d;
  fetch_pkt_t push_pkt;
  logic [1:0] count_q, count_d;
  logic [1:0] kept;

  assign push_pkt = '{pc: push_pc_i, instr: push_instr_i};

  // Pop shifts first, then the push lands in the first free slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    kept    = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (pop_i && (count_q != 2'd0)) begin
        head_d = tail_q;
        kept   = count_q - 2'd1;
      end
      count_d = kept;
      if (push_i && (kept != 2'd2)) begin
        if (kept == 2'd0) begin
          head_d = push_pkt;
        end else begin
          tail_d = push_pkt;
        end
        count_d = kept + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_pc_o    = head_q.pc;
  assign head_instr_o = head_q.instr;
  assign head_valid_o = (count_q != 2'd0);
  assign count_o      = count_q;

endmodule

// File: rtl/tiny_riscv_fetch.sv
// Fetch stage: owns the PC, strobes the synchronous instruction memory, buffers responses.
module tiny_riscv_fetch #(
  parameter int unsigned      XLEN     = tiny_riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = tiny_riscv_pkg::RESET_PC_DEFAULT
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  output logic [XLEN-1:0] o_mem_addr,
  output logic            o_read_strobe,
  input  logic [XLEN-1:0] i_mem_data,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_fault
);

  import tiny_riscv_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  logic       pop;
  logic       push;
  logic       redirect_run;
  logic [1:0] count;
  logic [2:0] occupancy;

  // Strobe only if the response is guaranteed a buffer slot after this cycle's pop.
  always_comb begin
    pop           = o_instr_valid & i_instr_ready;
    redirect_run  = i_redirect && (state_q == FETCH_RUN);
    push          = inflight_q && !i_redirect;
    occupancy     = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    o_read_strobe = i_Rst_n && (state_q == FETCH_RUN) && !i_redirect && (occupancy < 3'd2);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (o_read_strobe) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + XLEN'(4);
    end
    if (redirect_run) begin
      pc_d = i_redirect_pc;
      if (i_redirect_pc[1:0] != 2'b00) begin
        state_d = FETCH_FAULT;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= FETCH_RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  tiny_riscv_fetch_buffer u_buffer (
    .clk_i        (i_Clk),
    .rst_ni       (i_Rst_n),
    .push_i       (push),
    .push_pc_i    (inflight_pc_q),
    .push_instr_i (i_mem_data),
    .pop_i        (pop),
    .flush_i      (redirect_run),
    .head_pc_o    (o_instr_pc),
    .head_instr_o (o_instr),
    .head_valid_o (o_instr_valid),
    .count_o      (count)
  );

  assign o_mem_addr = pc_q;
  assign o_fault    = (state_q == FETCH_FAULT);

endmodule

// File: tb/tb_tiny_riscv_fetch.sv
// Bench for tiny_riscv_fetch: directed scenarios then random ready/redirect traffic vs a stream model.
module tb_tiny_riscv_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] target = '0;

  logic [31:0] mem_addr, mem_data, instr, instr_pc;
  logic        strobe, valid, fault;

  logic [31:0] w_mem_addr, w_mem_data, w_instr, w_instr_pc;
  logic        w_strobe, w_valid, w_fault;
  logic        w_ready = 1'b1;
  logic        w_redirect = 1'b0;
  logic [31:0] w_target = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tiny_riscv_fetch dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .o_mem_addr    (mem_addr),
    .o_read_strobe (strobe),
    .i_mem_data    (mem_data),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_instr_valid (valid),
    .i_instr_ready (ready),
    .i_redirect    (redirect),
    .i_redirect_pc (target),
    .o_fault       (fault)
  );

  tiny_riscv_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .o_mem_addr    (w_mem_addr),
    .o_read_strobe (w_strobe),
    .i_mem_data    (w_mem_data),
    .o_instr       (w_instr),
    .o_instr_pc    (w_instr_pc),
    .o_instr_valid (w_valid),
    .i_instr_ready (w_ready),
    .i_redirect    (w_redirect),
    .i_redirect_pc (w_target),
    .o_fault       (w_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) if (strobe)   mem_data   <= mem_word(mem_addr);
  always @(posedge clk) if (w_strobe) w_mem_data <= mem_word(w_mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Stream model: fetched-but-unaccepted count, next fetch PC, next beat PC, cycles since restart.
  bit          m_fault;
  int          m_out;
  int          m_since;
  logic [31:0] m_fetch_pc, m_exp_pc;
  int          w_since;
  logic [31:0] w_exp_pc;
  bit          m_acc, m_stb;

  function automatic bit m_valid();
    return !m_fault && (m_since >= 3);
  endfunction

  function automatic bit m_strobe();
    int pend;
    pend = m_out - ((m_valid() && ready) ? 1 : 0);
    return rst_n && !m_fault && !redirect && (pend < 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fault    = 1'b0;
      m_out      = 0;
      m_since    = 1;
      m_fetch_pc = 32'h0;
      m_exp_pc   = 32'h0;
      w_since    = 1;
      w_exp_pc   = 32'hFFFF_FFF8;
    end else begin
      m_acc = m_valid() && ready;
      m_stb = m_strobe();
      if (!m_fault && redirect) begin
        m_out      = 0;
        m_since    = 1;
        m_fetch_pc = target;
        m_exp_pc   = target;
        if (target[1:0] != 2'b00) m_fault = 1'b1;
      end else if (!m_fault) begin
        if (m_acc) begin
          m_exp_pc = m_exp_pc + 32'd4;
          m_out    = m_out - 1;
        end
        if (m_stb) begin
          m_out      = m_out + 1;
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (m_since < 3) m_since++;
      end
      if (w_since >= 3) w_exp_pc = w_exp_pc + 32'd4;
      if (w_since < 3) w_since++;
    end
  end

  always @(negedge clk) begin
    chk("fault", 32'(fault), 32'(m_fault));
    chk("valid", 32'(valid), 32'(m_valid()));
    chk("strobe", 32'(strobe), 32'(m_strobe()));
    chk("mem_addr", mem_addr, m_fetch_pc);
    if (m_valid()) begin
      chk("instr_pc", instr_pc, m_exp_pc);
      chk("instr", instr, mem_word(m_exp_pc));
    end
    if (!rst_n) begin
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
    end
    chk("wrap_valid", 32'(w_valid), 32'(w_since >= 3));
    if (w_since >= 3) begin
      chk("wrap_pc", w_instr_pc, w_exp_pc);
      chk("wrap_instr", w_instr, mem_word(w_exp_pc));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic reset_mid_cycle();
    redirect = 1'b0;
    #2 rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    #1 rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;

    // Startup stream, then a 5-cycle stall from the first valid beat.
    ready = 1'b1;
    cycles(2);
    ready = 1'b0;
    cycles(5);
    ready = 1'b1;
    cycles(4);

    // Aligned redirect, then a misaligned one, then an ignored one.
    redirect = 1'b1; target = 32'h40;
    cycles(1);
    redirect = 1'b0;
    cycles(6);
    redirect = 1'b1; target = 32'h42;
    cycles(1);
    redirect = 1'b0;
    cycles(3);
    redirect = 1'b1; target = 32'h0;
    cycles(1);
    redirect = 1'b0;
    cycles(2);
    reset_mid_cycle();
    cycles(6);
    reset_mid_cycle();

    for (int c = 0; c < 3000; c++) begin
      ready = ((c % 300) < 30) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (m_fault && ($urandom_range(0, 7) == 0)) begin
        reset_mid_cycle();
      end else begin
        r = $urandom_range(0, 99);
        redirect = 1'b0;
        if (r < 5) begin
          redirect = 1'b1;
          target   = 32'($urandom_range(0, 255)) << 2;
        end else if (r == 5) begin
          redirect = 1'b1;
          target   = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        end
        cycles(1);
      end
    end

    redirect = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
